data_mem_responder: RTL

Memory-side responder for the pipeline's data-memory request line. The controller asserts `req` for every `lw`/`sw`, and the MEM stage holds the instruction until this block answers. The block accepts one word access at a time and services it against an internal word-addressed RAM after a fixed, parameterised latency. It returns a one-cycle `ready` pulse with read data or an alignment error.

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word access at a time from the MEM stage.
// It answers after LATENCY cycles with a single-cycle ready pulse that carries load data or an alignment error.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state_r, state_s;
    logic [3:0]              cnt_r, cnt_s;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [31:0]             wdata_r;
    logic                    mis_r;
    logic                    ready_r, err_r, busy_r;
    logic [31:0]             rdata_r;

    logic                    acc_we_s;
    logic [ADDR_WIDTH-1:0]   acc_idx_s;
    logic [31:0]             acc_wdata_s;
    logic                    acc_mis_s;
    logic                    unused_s;

    logic [31:0] mem_r [0:(2**ADDR_WIDTH)-1];

    assign unused_s = ^addr[31:ADDR_WIDTH+2];

    // Next-state and latency counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    cnt_s = CNT_INIT;
                    if (CNT_INIT == 4'd0) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_s == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Access operands: with LATENCY=1 RESP is entered straight from IDLE, before anything is latched
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s    = we;
            acc_idx_s   = addr[ADDR_WIDTH+1:2];
            acc_wdata_s = wdata;
            acc_mis_s   = |addr[1:0];
        end else begin
            acc_we_s    = we_r;
            acc_idx_s   = idx_r;
            acc_wdata_s = wdata_r;
            acc_mis_s   = mis_r;
        end
    end

    // State, request latches and registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            idx_r   <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 32'd0;
            mis_r   <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != IDLE);
            ready_r <= (state_s == RESP);
            if (state_r == IDLE && req) begin
                we_r    <= we;
                idx_r   <= addr[ADDR_WIDTH+1:2];
                wdata_r <= wdata;
                mis_r   <= |addr[1:0];
            end
            if (state_s == RESP) begin
                err_r <= acc_mis_s;
                if (!acc_mis_s && !acc_we_s) begin
                    rdata_r <= mem_r[acc_idx_s];
                end else begin
                    rdata_r <= 32'd0;
                end
            end else begin
                err_r   <= 1'b0;
                rdata_r <= 32'd0;
            end
        end
    end

    // RAM write on the edge entering RESP; reset on that same edge suppresses it
    always_ff @(posedge clk) begin
        if (!reset && state_s == RESP && acc_we_s && !acc_mis_s) begin
            mem_r[acc_idx_s] <= acc_wdata_s;
        end
    end

    assign ready    = ready_r;
    assign rdata    = rdata_r;
    assign addr_err = err_r;
    assign busy     = busy_r;

endmodule
